// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared single-port RAM between an instruction-fetch port and a
// data (load/store) port, with fetch-starvation override and a sticky bus timeout.
module mem_port_arbiter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic        ram_en_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        mem_ready_q, mem_ready_d;
  logic [1:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        bus_err_q, bus_err_d;

  logic        mem_req;
  logic        mem_pend;
  logic        if_pend;
  logic        busy;

  // A requester whose ready pulse is high this cycle has just been served.
  assign mem_req  = mem_read_i | mem_write_i;
  assign mem_pend = mem_req & ~mem_ready_q;
  assign if_pend  = if_req_i & ~if_ready_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    starve_d    = if_req_i ? starve_q : 2'd0;
    tmo_d       = tmo_q;
    bus_err_d   = bus_err_q;

    case (state_q)
      IDLE: begin
        // Data wins unless fetch has lost three grants in a row.
        if (mem_pend && !(if_pend && starve_q == 2'd3)) begin
          state_d = MEM_BUSY;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          we_d    = mem_write_i;
          if (if_req_i && starve_q != 2'd3) begin
            starve_d = starve_q + 2'd1;
          end
        end else if (if_pend) begin
          state_d  = IF_BUSY;
          addr_d   = if_addr_i;
          we_d     = 1'b0;
          starve_d = 2'd0;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (ram_ack_i) begin
          state_d = IDLE;
          tmo_d   = '0;
          if (state_q == IF_BUSY) begin
            if_rdata_d = ram_rdata_i;
            if_ready_d = 1'b1;
          end else begin
            if (!we_q) begin
              mem_rdata_d = ram_rdata_i;
            end
            mem_ready_d = 1'b1;
          end
        end else if (tmo_q == 8'd254) begin
          // 255th silent cycle: give up, flag the error, release the requester.
          state_d     = IDLE;
          tmo_d       = '0;
          bus_err_d   = 1'b1;
          if_ready_d  = (state_q == IF_BUSY);
          mem_ready_d = (state_q == MEM_BUSY);
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_en_o    = busy;
  assign ram_we_o    = busy & we_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign mem_ready_o = mem_ready_q;
  assign bus_err_o   = bus_err_q;
  assign stall_if_o  = if_req_i & ~if_ready_q;
  assign stall_mem_o = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter, checked every cycle against
// a transaction-level model of the arbitration, latency and timeout rules.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        stall_if_o;
  logic        stall_mem_o;
  logic        ram_en_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        ram_ack_i;
  logic        bus_err_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .if_ready_o (if_ready_o),
    .mem_read_i (mem_read_i),
    .mem_write_i(mem_write_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .mem_ready_o(mem_ready_o),
    .stall_if_o (stall_if_o),
    .stall_mem_o(stall_mem_o),
    .ram_en_o   (ram_en_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i),
    .ram_ack_i  (ram_ack_i),
    .bus_err_o  (bus_err_o)
  );

  int vectorCount = 0;
  int missCount   = 0;

  // Model: who owns the RAM (0 none, 1 fetch, 2 data) and what the ports should show.
  int          mOwner;
  logic [31:0] mAddr, mWdata, mIfData, mMemData;
  bit          mWe, mIfRdy, mMemRdy, mErr;
  int          mStreak, mWait;

  // RAM responder and requester knobs.
  int          latency;
  int          age;
  bit          randLat, spurious, fixData, autoReq;
  logic [31:0] rdataFix;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task modelReset;
    mOwner = 0; mAddr = '0; mWdata = '0; mIfData = '0; mMemData = '0;
    mWe = 0; mIfRdy = 0; mMemRdy = 0; mErr = 0; mStreak = 0; mWait = 0;
  endtask

  task checkAll;
    checkOutput("ram_en", 32'(ram_en_o), 32'(mOwner != 0));
    checkOutput("ram_we", 32'(ram_we_o), 32'(mOwner == 2 && mWe));
    checkOutput("ram_addr", ram_addr_o, mAddr);
    checkOutput("ram_wdata", ram_wdata_o, mWdata);
    checkOutput("if_ready", 32'(if_ready_o), 32'(mIfRdy));
    checkOutput("mem_ready", 32'(mem_ready_o), 32'(mMemRdy));
    checkOutput("if_rdata", if_rdata_o, mIfData);
    checkOutput("mem_rdata", mem_rdata_o, mMemData);
    checkOutput("bus_err", 32'(bus_err_o), 32'(mErr));
    checkOutput("stall_if", 32'(stall_if_o), 32'(if_req_i && !mIfRdy));
    checkOutput("stall_mem", 32'(stall_mem_o), 32'((mem_read_i || mem_write_i) && !mMemRdy));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task modelNext;
    bit oIfRdy, oMemRdy, memP, ifP;
    if (reset_i) begin
      modelReset();
    end else begin
      oIfRdy  = mIfRdy;
      oMemRdy = mMemRdy;
      mIfRdy  = 0;
      mMemRdy = 0;
      if (mOwner == 0) begin
        memP = (mem_read_i || mem_write_i) && !oMemRdy;
        ifP  = if_req_i && !oIfRdy;
        if (memP && !(ifP && mStreak >= 3)) begin
          mOwner = 2; mAddr = mem_addr_i; mWdata = mem_wdata_i; mWe = mem_write_i;
          mStreak = if_req_i ? ((mStreak < 3) ? mStreak + 1 : 3) : 0;
        end else if (ifP) begin
          mOwner = 1; mAddr = if_addr_i; mWe = 0; mStreak = 0;
        end else if (!if_req_i) begin
          mStreak = 0;
        end
      end else begin
        if (!if_req_i) mStreak = 0;
        if (ram_ack_i) begin
          if (mOwner == 1) begin
            mIfData = ram_rdata_i; mIfRdy = 1;
          end else begin
            if (!mWe) mMemData = ram_rdata_i;
            mMemRdy = 1;
          end
          mOwner = 0; mWait = 0;
        end else if (mWait == 254) begin
          mErr = 1;
          if (mOwner == 1) mIfRdy = 1; else mMemRdy = 1;
          mOwner = 0; mWait = 0;
        end else begin
          mWait++;
        end
      end
    end
  endtask

  task newMemReq(input bit on);
    int k;
    if (on) begin
      k = $urandom_range(0, 2);
      mem_read_i  = (k != 1);
      mem_write_i = (k != 0);
      mem_addr_i  = $urandom;
      mem_wdata_i = $urandom;
    end else begin
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
    end
  endtask

  task applyStimulus;
    if (mOwner != 0) begin
      age++;
      if (age == 1 && randLat) latency = $urandom_range(1, 5);
      ram_ack_i   = (age >= latency);
      ram_rdata_i = fixData ? rdataFix : $urandom;
    end else begin
      age         = 0;
      ram_ack_i   = spurious && ($urandom_range(0, 5) == 0);
      ram_rdata_i = $urandom;
    end
    if (autoReq) begin
      if (if_req_i && mIfRdy) begin
        if_req_i  = 1'($urandom_range(0, 1));
        if_addr_i = $urandom;
      end else if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i  = 1'b1;
        if_addr_i = $urandom;
      end
      if ((mem_read_i || mem_write_i) && mMemRdy) newMemReq(1'($urandom_range(0, 1)));
      else if (!(mem_read_i || mem_write_i) && $urandom_range(0, 2) == 0) newMemReq(1'b1);
    end else begin
      if (mIfRdy) if_req_i = 1'b0;
      if (mMemRdy) begin
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
      end
    end
  endtask

  // Check mid-cycle, advance the model, then drive next inputs just after the edge.
  task stepCycle;
    #3;
    checkAll();
    modelNext();
    @(posedge clk_i);
    #1;
    applyStimulus();
  endtask

  initial begin
    int pulses, readyAt, ifEnAt, memRdyAt, ifRdyAt, stallDrops, grants, firstIf, weSeen;
    logic [31:0] firstAddr, sawAddr, sawWdata, keepData;
    bit prevEn, sawWe, gotFirst;

    reset_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
    ram_rdata_i = '0; ram_ack_i = 1'b0;
    latency = 3; age = 0; randLat = 0; spurious = 0; fixData = 1; autoReq = 0;
    rdataFix = 32'hDEADBEEF;
    modelReset();
    #1 reset_i = 1'b1;
    stepCycle();
    stepCycle();
    reset_i = 1'b0;
    stepCycle();

    $display("[TB] fetch with 3-cycle RAM latency");
    if_req_i = 1'b1; if_addr_i = 32'h100;
    pulses = 0; readyAt = -1; weSeen = 0;
    for (int i = 1; i <= 12; i++) begin
      stepCycle();
      if (if_ready_o) begin
        pulses++;
        if (readyAt < 0) readyAt = i;
      end
      if (ram_en_o && ram_we_o) weSeen++;
    end
    checkOutput("fetch_pulses", 32'(pulses), 32'd1);
    checkOutput("fetch_latency", 32'(readyAt), 32'd4);
    checkOutput("fetch_rdata", if_rdata_o, 32'hDEADBEEF);
    checkOutput("fetch_no_we", 32'(weSeen), 32'd0);

    $display("[TB] store");
    latency = 2; rdataFix = 32'hA5A5A5A5;
    mem_write_i = 1'b1; mem_addr_i = 32'h200; mem_wdata_i = 32'h55;
    pulses = 0; sawWe = 0; sawAddr = '0; sawWdata = '0;
    for (int i = 1; i <= 10; i++) begin
      stepCycle();
      if (mem_ready_o) pulses++;
      if (ram_en_o) begin
        sawWe = ram_we_o; sawAddr = ram_addr_o; sawWdata = ram_wdata_o;
      end
    end
    checkOutput("store_we", 32'(sawWe), 32'd1);
    checkOutput("store_addr", sawAddr, 32'h200);
    checkOutput("store_wdata", sawWdata, 32'h55);
    checkOutput("store_pulses", 32'(pulses), 32'd1);
    checkOutput("store_rdata_kept", mem_rdata_o, 32'h0);

    $display("[TB] fetch/load conflict");
    rdataFix = 32'h12345678;
    if_req_i = 1'b1; if_addr_i = 32'h300;
    mem_read_i = 1'b1; mem_addr_i = 32'h400;
    gotFirst = 0; firstAddr = '0; memRdyAt = -1; ifEnAt = -1; ifRdyAt = -1; stallDrops = 0;
    for (int i = 1; i <= 15; i++) begin
      stepCycle();
      if (ram_en_o && !gotFirst) begin
        gotFirst = 1; firstAddr = ram_addr_o;
      end
      if (mem_ready_o && memRdyAt < 0) memRdyAt = i;
      if (ram_en_o && ram_addr_o == 32'h300 && ifEnAt < 0) ifEnAt = i;
      if (if_ready_o && ifRdyAt < 0) ifRdyAt = i;
      if (ifRdyAt < 0 && !stall_if_o) stallDrops++;
    end
    checkOutput("conflict_mem_first", firstAddr, 32'h400);
    checkOutput("conflict_if_on_memready", 32'(ifEnAt - memRdyAt), 32'd1);
    checkOutput("conflict_stall_if_held", 32'(stallDrops), 32'd0);
    checkOutput("conflict_if_done", 32'(ifRdyAt > 0), 32'd1);
    checkOutput("conflict_load_data", mem_rdata_o, 32'h12345678);

    $display("[TB] fetch held against repeated loads");
    latency = 1;
    if_req_i = 1'b1; if_addr_i = 32'h700;
    mem_read_i = 1'b1; mem_addr_i = 32'h800;
    grants = 0; firstIf = 0; prevEn = 0;
    for (int i = 1; i <= 30; i++) begin
      stepCycle();
      if (ram_en_o && !prevEn) begin
        grants++;
        if (ram_addr_o == 32'h700 && firstIf == 0) firstIf = grants;
      end
      prevEn = ram_en_o;
      if (i < 20 && !mem_read_i && !mem_write_i) mem_read_i = 1'b1;
    end
    checkOutput("starve_if_by_4th", 32'(firstIf >= 1 && firstIf <= 4), 32'd1);

    $display("[TB] randomized traffic");
    fixData = 0; randLat = 1; spurious = 1; autoReq = 1;
    for (int i = 0; i < 3000; i++) stepCycle();
    autoReq = 0; spurious = 0;
    for (int i = 0; i < 30; i++) stepCycle();

    $display("[TB] timeout on silent RAM");
    randLat = 0; latency = 100000;
    keepData = mIfData;
    if_req_i = 1'b1; if_addr_i = 32'h500;
    readyAt = -1; pulses = 0;
    for (int i = 1; i <= 300; i++) begin
      stepCycle();
      if (if_ready_o) begin
        pulses++;
        if (readyAt < 0) readyAt = i;
      end
    end
    checkOutput("tmo_ready_cycle", 32'(readyAt), 32'd256);
    checkOutput("tmo_pulses", 32'(pulses), 32'd1);
    checkOutput("tmo_bus_err", 32'(bus_err_o), 32'd1);
    checkOutput("tmo_idle", 32'(ram_en_o), 32'd0);
    checkOutput("tmo_rdata_kept", if_rdata_o, keepData);

    $display("[TB] reset during data access");
    latency = 10; fixData = 1; rdataFix = 32'hCAFEF00D;
    mem_read_i = 1'b1; mem_write_i = 1'b0; mem_addr_i = 32'h600;
    for (int i = 0; i < 3; i++) stepCycle();
    reset_i = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_ram_en", 32'(ram_en_o), 32'd0);
    checkOutput("rst_bus_err", 32'(bus_err_o), 32'd0);
    checkOutput("rst_ram_addr", ram_addr_o, 32'h0);
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      if (mem_ready_o) pulses++;
    end
    checkOutput("rst_no_ready", 32'(pulses), 32'd0);
    reset_i = 1'b0; latency = 2;
    stepCycle();
    checkOutput("rst_first_grant", 32'(ram_en_o), 32'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      if (mem_ready_o) pulses++;
    end
    checkOutput("rst_after_pulses", 32'(pulses), 32'd1);
    checkOutput("rst_after_data", mem_rdata_o, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
